dram_burst_responder: RTL and testbench

//  Synthesizable DRAM responder: the slave end of the ORAM DRAM command/read/write

---
 rtl/dram_burst_responder_pkg.sv | 21 ++
 rtl/dram_burst_responder_if.sv | 41 ++++
 rtl/dram_resp_fifo.sv | 71 +++++++
 rtl/dram_burst_responder.sv | 131 +++++++++++++
 tb/tb_dram_burst_responder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_burst_responder_pkg.sv
// -----------------------------------------------------------------------------
// dram_burst_responder_pkg
//   Shared DDR3 local constants for the on-chip DRAM responder: command codes,
//   default bus widths and the column-to-beat address offset.
// -----------------------------------------------------------------------------
package dram_burst_responder_pkg;

    localparam int unsigned DDR3_AWIDTH = 28;   // command address width
    localparam int unsigned DDR3_CWIDTH = 3;    // command code width
    localparam int unsigned DDR3_DWIDTH = 512;  // data beat width
    localparam int unsigned DDR3_MWIDTH = DDR3_DWIDTH / 8;

    // One beat spans 8 column addresses, so the beat index starts at bit 3.
    localparam int unsigned BEAT_OFFSET = 3;

    typedef enum logic [2:0] {
        DDR3CMD_Write = 3'b000,
        DDR3CMD_Read  = 3'b001
    } ddr3_cmd_t;

endpackage

// File: rtl/dram_burst_responder_if.sv
// -----------------------------------------------------------------------------
// dram_burst_responder_if
//   MIG-style DRAM command / write-data / read-data bundle.
//   master : drives commands and write beats, receives read beats
//   slave  : the responder side
// -----------------------------------------------------------------------------
interface dram_burst_responder_if
    import dram_burst_responder_pkg::*;
#(
    parameter int unsigned DDRAWidth = DDR3_AWIDTH,
    parameter int unsigned DDRCWidth = DDR3_CWIDTH,
    parameter int unsigned DDRDWidth = DDR3_DWIDTH,
    parameter int unsigned DDRMWidth = DDR3_MWIDTH
) ();

    logic [DDRAWidth-1:0] DRAMAddress;
    logic [DDRCWidth-1:0] DRAMCommand;
    logic                 DRAMCommandValid;
    logic                 DRAMCommandReady;
    logic [DDRDWidth-1:0] DRAMReadData;
    logic                 DRAMReadDataValid;
    logic [DDRDWidth-1:0] DRAMWriteData;
    logic [DDRMWidth-1:0] DRAMWriteMask;
    logic                 DRAMWriteDataValid;
    logic                 DRAMWriteDataReady;

    modport master (
        output DRAMAddress, DRAMCommand, DRAMCommandValid,
        output DRAMWriteData, DRAMWriteMask, DRAMWriteDataValid,
        input  DRAMCommandReady, DRAMReadData, DRAMReadDataValid,
        input  DRAMWriteDataReady
    );

    modport slave (
        input  DRAMAddress, DRAMCommand, DRAMCommandValid,
        input  DRAMWriteData, DRAMWriteMask, DRAMWriteDataValid,
        output DRAMCommandReady, DRAMReadData, DRAMReadDataValid,
        output DRAMWriteDataReady
    );

endinterface

// File: rtl/dram_resp_fifo.sv
// -----------------------------------------------------------------------------
// dram_resp_fifo
//   Small valid/ready FIFO, power-of-2 depth, asynchronous active-high reset.
//   Ports:
//     clk, rst            clock, async reset (empties the FIFO)
//     in_data/valid/ready push side; in_ready is registered (not full)
//     out_data/valid      head entry, valid when non-empty
//     out_ready           pop request, honoured when out_valid
// -----------------------------------------------------------------------------
module dram_resp_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic [CntW-1:0]  count_next;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push      = in_valid & ready_q;
    assign out_valid = (count != '0);
    assign pop       = out_ready & out_valid;
    assign in_ready  = ready_q;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CntW'(1);
            2'b01:   count_next = count - CntW'(1);
            default: count_next = count;
        endcase
    end

    // Ready is a registered not-full flag: it is 0 throughout reset and never
    // looks at the same-cycle valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count   <= count_next;
            ready_q <= (count_next != CntW'(Depth));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/dram_burst_responder.sv
// -----------------------------------------------------------------------------
// dram_burst_responder
//   On-chip stand-in for MIG + DDR3: queues commands and write beats, executes
//   commands in order against a byte-enabled RAM, returns read beats after a
//   fixed ReadLatency.
//   Ports:
//     Clock, Reset    single clock, async active-high reset
//     bus             slave side of the DRAM command/read/write bundle
//     IllegalCommand  sticky flag, set when an unknown command code executes
// -----------------------------------------------------------------------------
module dram_burst_responder
    import dram_burst_responder_pkg::*;
#(
    parameter int unsigned DDRAWidth   = DDR3_AWIDTH,
    parameter int unsigned DDRCWidth   = DDR3_CWIDTH,
    parameter int unsigned DDRDWidth   = DDR3_DWIDTH,
    parameter int unsigned DDRMWidth   = DDR3_MWIDTH,
    parameter int unsigned MemAWidth   = 10,
    parameter int unsigned CmdDepth    = 4,
    parameter int unsigned WDDepth     = 4,
    parameter int unsigned ReadLatency = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    dram_burst_responder_if.slave   bus,
    output logic                    IllegalCommand
);

    localparam int unsigned CmdW = DDRCWidth + DDRAWidth;
    localparam int unsigned WdW  = DDRDWidth + DDRMWidth;

    logic [CmdW-1:0]      cmd_head;
    logic                 cmd_valid;
    logic                 cmd_pop;
    logic [DDRCWidth-1:0] head_cmd;
    logic [DDRAWidth-1:0] head_addr;
    logic                 addr_unused;

    logic [WdW-1:0]       wd_head;
    logic                 wd_valid;
    logic [DDRDWidth-1:0] wd_data;
    logic [DDRMWidth-1:0] wd_mask;

    logic [MemAWidth-1:0] beat_idx;
    logic                 is_read;
    logic                 is_write;
    logic                 do_read;
    logic                 do_write;
    logic                 do_ill;

    logic [DDRDWidth-1:0] ram [2**MemAWidth];

    logic                 pipe_valid [ReadLatency];
    logic [DDRDWidth-1:0] pipe_data  [ReadLatency];

    dram_resp_fifo #(
        .Width (CmdW),
        .Depth (CmdDepth)
    ) u_cmd_fifo (
        .clk       (Clock),
        .rst       (Reset),
        .in_data   ({bus.DRAMCommand, bus.DRAMAddress}),
        .in_valid  (bus.DRAMCommandValid),
        .in_ready  (bus.DRAMCommandReady),
        .out_data  (cmd_head),
        .out_valid (cmd_valid),
        .out_ready (cmd_pop)
    );

    dram_resp_fifo #(
        .Width (WdW),
        .Depth (WDDepth)
    ) u_wd_fifo (
        .clk       (Clock),
        .rst       (Reset),
        .in_data   ({bus.DRAMWriteData, bus.DRAMWriteMask}),
        .in_valid  (bus.DRAMWriteDataValid),
        .in_ready  (bus.DRAMWriteDataReady),
        .out_data  (wd_head),
        .out_valid (wd_valid),
        .out_ready (do_write)
    );

    assign {head_cmd, head_addr} = cmd_head;
    assign {wd_data, wd_mask}    = wd_head;

    // Address bits outside the beat index alias onto the same RAM word.
    assign beat_idx    = head_addr[BEAT_OFFSET +: MemAWidth];
    assign addr_unused = ^head_addr;

    assign is_read  = (head_cmd == DDRCWidth'(DDR3CMD_Read));
    assign is_write = (head_cmd == DDRCWidth'(DDR3CMD_Write));

    // A write at the head stalls the whole queue until its beat is available.
    assign do_read  = cmd_valid & is_read;
    assign do_write = cmd_valid & is_write & wd_valid;
    assign do_ill   = cmd_valid & ~is_read & ~is_write;
    assign cmd_pop  = do_read | do_write | do_ill;

    always_ff @(posedge Clock) begin
        if (do_write) begin
            for (int unsigned b = 0; b < DDRMWidth; b++) begin
                if (!wd_mask[b]) ram[beat_idx][b*8 +: 8] <= wd_data[b*8 +: 8];
            end
        end
    end

    // Stage 0 is the synchronous RAM read itself; the beat leaves the last
    // stage exactly ReadLatency cycles after the pop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
            end
            IllegalCommand <= 1'b0;
        end else begin
            pipe_valid[0] <= do_read;
            if (do_read) pipe_data[0] <= ram[beat_idx];
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            if (do_ill) IllegalCommand <= 1'b1;
        end
    end

    assign bus.DRAMReadDataValid = pipe_valid[ReadLatency-1];
    assign bus.DRAMReadData      = pipe_data[ReadLatency-1];

endmodule

// File: tb/tb_dram_burst_responder.sv
// -----------------------------------------------------------------------------
// tb_dram_burst_responder
//   Self-checking bench for dram_burst_responder. A bench-side memory model
//   produces expected read beats, queued when a read is issued and compared
//   as beats emerge.
// -----------------------------------------------------------------------------
module tb_dram_burst_responder;
    import dram_burst_responder_pkg::*;

    localparam int unsigned AW  = 28;
    localparam int unsigned CW  = 3;
    localparam int unsigned DW  = 512;
    localparam int unsigned MW  = 64;
    localparam int unsigned MAW = 10;
    localparam int unsigned LAT = 4;
    localparam int          BUDGET = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic illegal;

    always #5 clk = ~clk;

    dram_burst_responder_if #(
        .DDRAWidth (AW),
        .DDRCWidth (CW),
        .DDRDWidth (DW),
        .DDRMWidth (MW)
    ) bus ();

    dram_burst_responder #(
        .DDRAWidth   (AW),
        .DDRCWidth   (CW),
        .DDRDWidth   (DW),
        .DDRMWidth   (MW),
        .MemAWidth   (MAW),
        .CmdDepth    (4),
        .WDDepth     (4),
        .ReadLatency (LAT)
    ) dut (
        .Clock          (clk),
        .Reset          (rst),
        .bus            (bus.slave),
        .IllegalCommand (illegal)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] model [int];

    int unsigned cyc = 0;
    int unsigned win_beats = 0;
    int unsigned first_cyc = 0;
    int unsigned last_cyc  = 0;
    int unsigned accept_cyc = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.DRAMReadDataValid) begin
            if (win_beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            win_beats++;
            check("beat_expected", 512'(sb.size() != 0), 512'(1));
            if (sb.size() != 0) check("rd_data", bus.DRAMReadData, sb.pop_front());
        end
    end

    function automatic int beat_of(input logic [AW-1:0] a);
        return int'(a[BEAT_OFFSET +: MAW]);
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [MW-1:0] m);
        logic [DW-1:0] cur;
        cur = model.exists(beat_of(a)) ? model[beat_of(a)] : '0;
        for (int b = 0; b < int'(MW); b++)
            if (!m[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        model[beat_of(a)] = cur;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int j = 0; j < int'(DW / 32); j++) d[j*32 +: 32] = $urandom();
        return d;
    endfunction

    // All drive tasks start and end at posedge+1 so consecutive calls are gapless.
    task automatic send_cmd(input logic [CW-1:0] c, input logic [AW-1:0] a);
        int n = 0;
        bus.DRAMCommand      = c;
        bus.DRAMAddress      = a;
        bus.DRAMCommandValid = 1'b1;
        @(negedge clk);
        while (!bus.DRAMCommandReady && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        accept_cyc = cyc;
        check("cmd_accept_budget", 512'(n < BUDGET), 512'(1));
        @(posedge clk);
        #1 bus.DRAMCommandValid = 1'b0;
    endtask

    task automatic send_wdata(input logic [DW-1:0] d, input logic [MW-1:0] m);
        int n = 0;
        bus.DRAMWriteData      = d;
        bus.DRAMWriteMask      = m;
        bus.DRAMWriteDataValid = 1'b1;
        @(negedge clk);
        while (!bus.DRAMWriteDataReady && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("wd_accept_budget", 512'(n < BUDGET), 512'(1));
        @(posedge clk);
        #1 bus.DRAMWriteDataValid = 1'b0;
    endtask

    task automatic write_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        model_write(a, d, m);
        fork
            send_cmd(3'(DDR3CMD_Write), a);
            send_wdata(d, m);
        join
    endtask

    task automatic read_exp(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        sb.push_back(exp);
        send_cmd(3'(DDR3CMD_Read), a);
    endtask

    task automatic read(input logic [AW-1:0] a);
        read_exp(a, model[beat_of(a)]);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int unsigned target, input string tag);
        int n = 0;
        while (win_beats < target && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 512'(win_beats), 512'(target));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("drain", 512'(sb.size()), 512'(0));
        cycles(2);
    endtask

    initial begin
        logic [DW-1:0] d;
        int n;

        bus.DRAMAddress        = '0;
        bus.DRAMCommand        = '0;
        bus.DRAMCommandValid   = 1'b0;
        bus.DRAMWriteData      = '0;
        bus.DRAMWriteMask      = '0;
        bus.DRAMWriteDataValid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 512'(bus.DRAMCommandReady), 512'(0));
        check("rst_wd_ready", 512'(bus.DRAMWriteDataReady), 512'(0));
        check("rst_rd_valid", 512'(bus.DRAMReadDataValid), 512'(0));
        check("rst_rd_data", bus.DRAMReadData, '0);
        check("rst_illegal", 512'(illegal), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_cmd_ready", 512'(bus.DRAMCommandReady), 512'(1));
        check("post_rst_wd_ready", 512'(bus.DRAMWriteDataReady), 512'(1));
        cycles(1);

        // Basic write then read, with latency: pop is one cycle after accept,
        // beat is LAT cycles after pop.
        write_beat(28'h000, {64{8'hA5}}, '0);
        cycles(3);
        win_beats = 0;
        read_exp(28'h000, {64{8'hA5}});
        wait_beats(1, "lat_beat_count");
        check("rd_latency", 512'(last_cyc - accept_cyc), 512'(1 + LAT));
        check("illegal_after_rw", 512'(illegal), 512'(0));

        // Write beat arrives well ahead of its command
        d = rand_beat();
        send_wdata(d, '0);
        @(negedge clk);
        check("early_wd_ready", 512'(bus.DRAMWriteDataReady), 512'(1));
        cycles(3);
        model_write(28'h010, d, '0);
        send_cmd(3'(DDR3CMD_Write), 28'h010);
        read(28'h010);

        // Masked write: only byte 0 updated
        write_beat(28'h000, {64{8'h3C}}, 64'hFFFF_FFFF_FFFF_FFFE);
        read_exp(28'h000, {{63{8'hA5}}, 8'h3C});
        drain();

        // Eight back-to-back reads
        for (int i = 0; i < 8; i++) write_beat(28'(i * 8), rand_beat(), '0);
        cycles(2);
        win_beats = 0;
        for (int i = 0; i < 8; i++) read(28'(i * 8));
        wait_beats(8, "b2b_count");
        check("b2b_span", 512'(last_cyc - first_cyc), 512'(7));
        drain();

        // Write stalled at head without data fills the command FIFO
        d = rand_beat();
        model_write(28'h040, d, '0);
        win_beats = 0;
        send_cmd(3'(DDR3CMD_Write), 28'h040);
        read(28'h040);
        read(28'h008);
        read(28'h010);
        @(negedge clk);
        check("stall_cmd_ready", 512'(bus.DRAMCommandReady), 512'(0));
        check("stall_no_beats", 512'(win_beats), 512'(0));
        cycles(1);
        send_wdata(d, '0);
        drain();

        // Write-data FIFO fills when no write commands are queued
        for (int i = 0; i < 4; i++) begin
            d = rand_beat();
            model_write(28'(12'h100 + i * 8), d, '0);
            send_wdata(d, '0);
        end
        @(negedge clk);
        check("wd_full_ready", 512'(bus.DRAMWriteDataReady), 512'(0));
        cycles(1);
        for (int i = 0; i < 4; i++) send_cmd(3'(DDR3CMD_Write), 28'(12'h100 + i * 8));
        for (int i = 0; i < 4; i++) read(28'(12'h100 + i * 8));
        drain();

        // Address alias: upper bits ignored
        read(28'hA00_0010);
        drain();

        // Illegal command
        win_beats = 0;
        send_cmd(3'b010, 28'h000);
        cycles(10);
        check("illegal_no_beat", 512'(win_beats), 512'(0));
        check("illegal_flag", 512'(illegal), 512'(1));
        read(28'h000);
        drain();
        check("illegal_sticky", 512'(illegal), 512'(1));

        // Reset with reads in flight
        win_beats = 0;
        read(28'h008);
        send_cmd(3'(DDR3CMD_Read), 28'h010);
        n = 0;
        @(negedge clk);
        while (!bus.DRAMReadDataValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("inflight_first_beat", 512'(bus.DRAMReadDataValid), 512'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", 512'(bus.DRAMReadDataValid), 512'(0));
        check("rst_mid_data", bus.DRAMReadData, '0);
        check("rst_mid_illegal", 512'(illegal), 512'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycles(12);
        check("rst_discard_beats", 512'(win_beats), 512'(1));
        read(28'h000);
        read(28'h010);
        read(28'h040);
        drain();
        check("sb_empty", 512'(sb.size()), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
